// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative write-through data cache.
//   state_t    : controller states
//   addr_index : set index field of a byte address (low index_w bits)
//   addr_tag   : tag field of a byte address (bits above the index)
// Callers pass the address zero-extended to 32 bits and narrow the result
// with a cast, which keeps the helpers independent of ADDR_W.
package dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_BUS_WAIT,
    S_MEM,
    S_RESP
  } state_t;

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
    return addr & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
    return addr >> index_w;
  endfunction

endpackage

// File: rtl/set_assoc_dcache_if.sv
// Core-side and memory-bus-side signals of the data cache.
//   slave  : the cache's view (takes core requests, drives the memory bus)
//   master : the environment's view (core, arbiter and memory)
// Signals:
//   core_req/core_rw/core_addr/core_wdata  core request, held until core_ack
//   flush                                  invalidate all lines (IDLE only)
//   core_ack/core_rdata/core_hit           completion pulse, read data, lookup result
//   flush_done                             one-cycle pulse after a flush
//   bus_req/bus_grant                      bus arbitration
//   mem_valid/mem_rw/mem_addr/mem_wdata    memory command
//   mem_ready/mem_rdata                    memory completion and fill data
interface set_assoc_dcache_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              core_req;
  logic              core_rw;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              flush;
  logic              core_ack;
  logic [DATA_W-1:0] core_rdata;
  logic              core_hit;
  logic              flush_done;
  logic              bus_req;
  logic              bus_grant;
  logic              mem_valid;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_rw, core_addr, core_wdata, flush,
    input  bus_grant, mem_ready, mem_rdata,
    output core_ack, core_rdata, core_hit, flush_done,
    output bus_req, mem_valid, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_rw, core_addr, core_wdata, flush,
    output bus_grant, mem_ready, mem_rdata,
    input  core_ack, core_rdata, core_hit, flush_done,
    input  bus_req, mem_valid, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_way.sv
// One way of the cache: valid bits, tag array and data array.
// Ports:
//   clk, reset     clock; synchronous active-high reset clears valid bits only
//   i_inv_all      clear every valid bit this cycle
//   i_rd_idx       combinational lookup index -> o_valid, o_tag, o_data
//   i_wr_en        write tag/data at i_wr_idx and mark the line valid
//   i_wr_idx, i_wr_tag, i_wr_data
module dcache_way #(
  parameter int SETS    = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_inv_all,
  input  logic [INDEX_W-1:0] i_rd_idx,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [DATA_W-1:0]  o_data,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [DATA_W-1:0]  i_wr_data
);

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS];

  always_ff @(posedge clk) begin
    if (reset || i_inv_all) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx];

endmodule

// File: rtl/set_assoc_dcache.sv
// Write-through, read-allocate / no-write-allocate data cache with WAYS-way
// set associativity (WAYS = 1 or 2), per-set LRU bit and single-cycle flush.
// Ports:
//   clk    clock
//   reset  synchronous active-high; aborts any transaction in flight
//   bus    set_assoc_dcache_if.slave: core request/response, flush, bus
//          arbitration and memory handshake
// Flow: IDLE -> LOOKUP -> RESP (read hit)
//                      -> BUS_WAIT -> MEM -> RESP (read miss, any write)
module set_assoc_dcache
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  set_assoc_dcache_if.slave bus
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  state_t            r_state;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_hit;
  logic              r_victim;
  logic [SETS-1:0]   r_lru;

  logic              r_core_ack;
  logic [DATA_W-1:0] r_core_rdata;
  logic              r_core_hit;
  logic              r_flush_done;
  logic              r_bus_req;
  logic              r_mem_valid;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [WAYS-1:0]    w_valid;
  logic [WAYS-1:0]    w_hit_vec;
  logic [WAYS-1:0]    w_wr_en;
  logic [TAG_W-1:0]   w_way_tag  [WAYS];
  logic [DATA_W-1:0]  w_way_data [WAYS];
  logic               w_hit;
  logic               w_hit_way;
  logic [DATA_W-1:0]  w_hit_data;
  logic               w_victim;
  logic               w_found;
  logic               w_inv_all;
  logic               w_wr_hit;
  logic               w_fill;
  logic [DATA_W-1:0]  w_wr_data;

  // The latched request address drives the lookup for the whole transaction.
  assign w_idx = INDEX_W'(addr_index(32'(r_addr), INDEX_W));
  assign w_tag = TAG_W'(addr_tag(32'(r_addr), INDEX_W));

  // Array updates are suppressed under reset so an aborted fill leaves no trace.
  assign w_inv_all = !reset && (r_state == S_IDLE) && bus.flush;
  assign w_wr_hit  = !reset && (r_state == S_LOOKUP) && r_rw && w_hit;
  assign w_fill    = !reset && (r_state == S_MEM) && r_mem_valid && bus.mem_ready && !r_rw;
  assign w_wr_data = w_fill ? bus.mem_rdata : r_wdata;
  assign w_hit     = |w_hit_vec;

  always_comb begin
    w_hit_vec  = '0;
    w_hit_way  = 1'b0;
    w_hit_data = '0;
    w_victim   = 1'b0;
    w_found    = 1'b0;
    w_wr_en    = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = w_valid[w] && (w_way_tag[w] == w_tag);
      if (w_hit_vec[w]) begin
        w_hit_way  = 1'(w);
        w_hit_data = w_way_data[w];
      end
      // Lowest-numbered invalid way wins before LRU is consulted.
      if (!w_found && !w_valid[w]) begin
        w_victim = 1'(w);
        w_found  = 1'b1;
      end
    end
    if (!w_found && (WAYS > 1)) begin
      w_victim = r_lru[w_idx];
    end
    for (int w = 0; w < WAYS; w++) begin
      w_wr_en[w] = (w_wr_hit && w_hit_vec[w]) || (w_fill && (r_victim == 1'(w)));
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way #(
      .SETS    (SETS),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
    ) u_way (
      .clk       (clk),
      .reset     (reset),
      .i_inv_all (w_inv_all),
      .i_rd_idx  (w_idx),
      .o_valid   (w_valid[g]),
      .o_tag     (w_way_tag[g]),
      .o_data    (w_way_data[g]),
      .i_wr_en   (w_wr_en[g]),
      .i_wr_idx  (w_idx),
      .i_wr_tag  (w_tag),
      .i_wr_data (w_wr_data)
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lru        <= '0;
      r_core_ack   <= 1'b0;
      r_core_rdata <= '0;
      r_core_hit   <= 1'b0;
      r_flush_done <= 1'b0;
      r_bus_req    <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_core_ack   <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.flush) begin
            r_lru        <= '0;
            r_flush_done <= 1'b1;
          end else if (bus.core_req) begin
            r_rw    <= bus.core_rw;
            r_addr  <= bus.core_addr;
            r_wdata <= bus.core_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit    <= w_hit;
          r_victim <= w_victim;
          // LRU bit names the way that was not just touched.
          if (w_hit && (WAYS > 1)) begin
            r_lru[w_idx] <= ~w_hit_way;
          end
          if (!r_rw && w_hit) begin
            r_core_rdata <= w_hit_data;
            r_core_hit   <= 1'b1;
            r_core_ack   <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_bus_req <= 1'b1;
            r_state   <= S_BUS_WAIT;
          end
        end
        S_BUS_WAIT: begin
          if (bus.bus_grant) begin
            r_mem_valid <= 1'b1;
            r_mem_rw    <= r_rw;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= S_MEM;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            r_bus_req   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_core_ack  <= 1'b1;
            r_state     <= S_RESP;
            if (r_rw) begin
              r_core_hit <= r_hit;
            end else begin
              r_core_hit   <= 1'b0;
              r_core_rdata <= bus.mem_rdata;
              if (WAYS > 1) begin
                r_lru[w_idx] <= ~r_victim;
              end
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.core_ack   = r_core_ack;
  assign bus.core_rdata = r_core_rdata;
  assign bus.core_hit   = r_core_hit;
  assign bus.flush_done = r_flush_done;
  assign bus.bus_req    = r_bus_req;
  assign bus.mem_valid  = r_mem_valid;
  assign bus.mem_rw     = r_mem_rw;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_set_assoc_dcache.sv
// Directed, table-driven bench for set_assoc_dcache (ADDR_W=9, SETS=16, WAYS=2).
// Each table row is a core access (or a flush) with the expected response;
// a responder loop plays arbiter and memory with programmable delays.
module tb_set_assoc_dcache;

  localparam int OP_ACC      = 0;
  localparam int OP_FLUSH    = 1;
  localparam int OP_FLUSHREQ = 2;
  localparam int NV          = 20;

  typedef struct {
    int         op;
    logic       rw;
    logic [8:0] addr;
    logic [7:0] wd;
    logic [7:0] md;
    int         gdly;
    int         mdly;
    logic [7:0] e_rd;
    logic       chk_rd;
    logic       e_hit;
    logic       e_bus;
    int         e_lat;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic       o_rdata_hit;
  logic [7:0] o_rdata;
  logic       o_bus;
  logic       o_mrw;
  logic [8:0] o_maddr;
  logic [7:0] o_mwdata;
  int         o_lat;
  int         o_err;
  logic       o_to;

  vec_t tv [NV];

  set_assoc_dcache_if #(.ADDR_W(9), .DATA_W(8)) bus ();

  set_assoc_dcache #(
    .ADDR_W (9),
    .DATA_W (8),
    .SETS   (16),
    .WAYS   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
    end
  endtask

  // Drives one request and acts as arbiter + memory until core_ack.
  task automatic run_access(input logic rw, input logic [8:0] addr, input logic [7:0] wd,
                            input logic [7:0] md, input int gdly, input int mdly);
    int gcnt;
    int mcnt;
    bit done;
    bit seen_mem;
    gcnt = 0; mcnt = 0; done = 0; seen_mem = 0;
    o_bus = 0; o_err = 0; o_lat = 0; o_to = 0; o_rdata_hit = 0;
    o_rdata = '0; o_mrw = 0; o_maddr = '0; o_mwdata = '0;
    bus.core_req = 1'b1; bus.core_rw = rw; bus.core_addr = addr; bus.core_wdata = wd;
    while (!done) begin
      @(posedge clk); #1;
      o_lat++;
      if (o_lat > 60) begin
        o_to = 1; done = 1;
      end else begin
        if (bus.bus_req) o_bus = 1;
        if (bus.mem_valid) begin
          if (!seen_mem) begin
            o_mrw = bus.mem_rw; o_maddr = bus.mem_addr; o_mwdata = bus.mem_wdata;
            seen_mem = 1;
          end else if (bus.mem_rw !== o_mrw || bus.mem_addr !== o_maddr ||
                       bus.mem_wdata !== o_mwdata) begin
            o_err++;
          end
          if (!bus.bus_req) o_err++;
          if (mcnt == mdly) begin
            bus.mem_ready = 1'b1; bus.mem_rdata = md;
          end else begin
            mcnt++; bus.mem_ready = 1'b0; bus.mem_rdata = 8'hEE;
          end
        end else begin
          bus.mem_ready = 1'b0; bus.mem_rdata = 8'hEE;
        end
        if (bus.bus_req && !bus.bus_grant) begin
          if (gcnt == gdly) bus.bus_grant = 1'b1;
          else gcnt++;
        end else if (!bus.bus_req) begin
          bus.bus_grant = 1'b0;
        end
        if (bus.core_ack) begin
          o_rdata = bus.core_rdata; o_rdata_hit = bus.core_hit;
          if (bus.bus_req || bus.mem_valid) o_err++;
          done = 1;
        end
      end
    end
    bus.core_req = 1'b0; bus.mem_ready = 1'b0; bus.bus_grant = 1'b0;
    @(posedge clk); #1;
    if (bus.core_ack || bus.bus_req || bus.mem_valid) o_err++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    //           op          rw    addr    wd     md     g  m  e_rd   chk  hit  bus  lat
    tv[0]  = '{OP_ACC,      1'b0, 9'h025, 8'h00, 8'hA5, 0, 0, 8'hA5, 1'b1, 1'b0, 1'b1, 4};
    tv[1]  = '{OP_ACC,      1'b0, 9'h025, 8'h00, 8'h00, 0, 0, 8'hA5, 1'b1, 1'b1, 1'b0, 2};
    tv[2]  = '{OP_ACC,      1'b1, 9'h025, 8'h5A, 8'h00, 1, 0, 8'h00, 1'b0, 1'b1, 1'b1, 5};
    tv[3]  = '{OP_ACC,      1'b0, 9'h025, 8'h00, 8'h00, 0, 0, 8'h5A, 1'b1, 1'b1, 1'b0, 2};
    tv[4]  = '{OP_ACC,      1'b1, 9'h105, 8'h33, 8'h00, 0, 2, 8'h00, 1'b0, 1'b0, 1'b1, 6};
    tv[5]  = '{OP_ACC,      1'b0, 9'h105, 8'h00, 8'h77, 0, 0, 8'h77, 1'b1, 1'b0, 1'b1, 4};
    tv[6]  = '{OP_ACC,      1'b0, 9'h025, 8'h00, 8'h00, 0, 0, 8'h5A, 1'b1, 1'b1, 1'b0, 2};
    tv[7]  = '{OP_ACC,      1'b0, 9'h105, 8'h00, 8'h00, 0, 0, 8'h77, 1'b1, 1'b1, 1'b0, 2};
    tv[8]  = '{OP_ACC,      1'b0, 9'h03A, 8'h00, 8'hC3, 0, 0, 8'hC3, 1'b1, 1'b0, 1'b1, 4};
    tv[9]  = '{OP_FLUSHREQ, 1'b0, 9'h025, 8'h00, 8'h44, 0, 0, 8'h44, 1'b1, 1'b0, 1'b1, 4};
    tv[10] = '{OP_ACC,      1'b0, 9'h03A, 8'h00, 8'h3C, 0, 0, 8'h3C, 1'b1, 1'b0, 1'b1, 4};
    tv[11] = '{OP_FLUSH,    1'b0, 9'h000, 8'h00, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0};
    tv[12] = '{OP_ACC,      1'b0, 9'h005, 8'h00, 8'h50, 0, 0, 8'h50, 1'b1, 1'b0, 1'b1, 4};
    tv[13] = '{OP_ACC,      1'b0, 9'h015, 8'h00, 8'h51, 2, 1, 8'h51, 1'b1, 1'b0, 1'b1, 7};
    tv[14] = '{OP_ACC,      1'b0, 9'h005, 8'h00, 8'h00, 0, 0, 8'h50, 1'b1, 1'b1, 1'b0, 2};
    tv[15] = '{OP_ACC,      1'b0, 9'h025, 8'h00, 8'h52, 0, 0, 8'h52, 1'b1, 1'b0, 1'b1, 4};
    tv[16] = '{OP_ACC,      1'b0, 9'h005, 8'h00, 8'h00, 0, 0, 8'h50, 1'b1, 1'b1, 1'b0, 2};
    tv[17] = '{OP_ACC,      1'b0, 9'h015, 8'h00, 8'h53, 0, 0, 8'h53, 1'b1, 1'b0, 1'b1, 4};
    tv[18] = '{OP_ACC,      1'b0, 9'h005, 8'h00, 8'h00, 0, 0, 8'h50, 1'b1, 1'b1, 1'b0, 2};
    tv[19] = '{OP_ACC,      1'b0, 9'h015, 8'h00, 8'h00, 0, 0, 8'h53, 1'b1, 1'b1, 1'b0, 2};

    reset = 1'b1;
    bus.core_req = 1'b0; bus.core_rw = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.flush = 1'b0; bus.bus_grant = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_ack",   32'(bus.core_ack),   32'd0);
    chk("rst_core_rdata", 32'(bus.core_rdata), 32'd0);
    chk("rst_core_hit",   32'(bus.core_hit),   32'd0);
    chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
    chk("rst_bus_req",    32'(bus.bus_req),    32'd0);
    chk("rst_mem_valid",  32'(bus.mem_valid),  32'd0);
    chk("rst_mem_rw",     32'(bus.mem_rw),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (tv[i].op == OP_FLUSH || tv[i].op == OP_FLUSHREQ) begin
        bus.flush = 1'b1;
        if (tv[i].op == OP_FLUSHREQ) begin
          bus.core_req = 1'b1; bus.core_rw = tv[i].rw;
          bus.core_addr = tv[i].addr; bus.core_wdata = tv[i].wd;
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_flush_done", i), 32'(bus.flush_done), 32'd1);
        chk($sformatf("v%0d_flush_noack", i), 32'(bus.core_ack), 32'd0);
        bus.flush = 1'b0;
        if (tv[i].op == OP_FLUSH) begin
          @(posedge clk); #1;
          chk($sformatf("v%0d_flush_pulse", i), 32'(bus.flush_done), 32'd0);
        end
      end
      if (tv[i].op == OP_ACC || tv[i].op == OP_FLUSHREQ) begin
        run_access(tv[i].rw, tv[i].addr, tv[i].wd, tv[i].md, tv[i].gdly, tv[i].mdly);
        chk($sformatf("v%0d_timeout", i), 32'(o_to), 32'd0);
        chk($sformatf("v%0d_hit", i), 32'(o_rdata_hit), 32'(tv[i].e_hit));
        chk($sformatf("v%0d_bus", i), 32'(o_bus), 32'(tv[i].e_bus));
        chk($sformatf("v%0d_latency", i), 32'(o_lat), 32'(tv[i].e_lat));
        chk($sformatf("v%0d_protocol", i), 32'(o_err), 32'd0);
        if (tv[i].chk_rd) chk($sformatf("v%0d_rdata", i), 32'(o_rdata), 32'(tv[i].e_rd));
        if (tv[i].e_bus) begin
          chk($sformatf("v%0d_mem_rw", i), 32'(o_mrw), 32'(tv[i].rw));
          chk($sformatf("v%0d_mem_addr", i), 32'(o_maddr), 32'(tv[i].addr));
          if (tv[i].rw) chk($sformatf("v%0d_mem_wdata", i), 32'(o_mwdata), 32'(tv[i].wd));
        end
      end
    end

    // Reset while the memory command is outstanding, with mem_ready arriving
    // on the same edge: the transaction must vanish without an ack.
    begin
      int  n;
      int  acks;
      bit  seen;
      seen = 0;
      bus.core_req = 1'b1; bus.core_rw = 1'b0; bus.core_addr = 9'h0F7; bus.core_wdata = '0;
      for (n = 0; n < 20 && !seen; n++) begin
        @(posedge clk); #1;
        bus.bus_grant = bus.bus_req;
        if (bus.mem_valid) seen = 1;
      end
      chk("rstmem_reached_mem", 32'(seen), 32'd1);
      reset = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 8'h99;
      @(posedge clk); #1;
      reset = 1'b0; bus.mem_ready = 1'b0; bus.core_req = 1'b0; bus.bus_grant = 1'b0;
      chk("rstmem_bus_req",   32'(bus.bus_req),   32'd0);
      chk("rstmem_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rstmem_core_ack",  32'(bus.core_ack),  32'd0);
      chk("rstmem_rdata",     32'(bus.core_rdata), 32'd0);
      acks = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (bus.core_ack || bus.bus_req || bus.mem_valid) acks++;
      end
      chk("rstmem_quiet", 32'(acks), 32'd0);
      run_access(1'b0, 9'h0F7, 8'h00, 8'h61, 0, 0);
      chk("rstmem_f7_hit", 32'(o_rdata_hit), 32'd0);
      chk("rstmem_f7_rdata", 32'(o_rdata), 32'h61);
      run_access(1'b0, 9'h005, 8'h00, 8'h62, 0, 0);
      chk("rstmem_005_hit", 32'(o_rdata_hit), 32'd0);
      chk("rstmem_005_rdata", 32'(o_rdata), 32'h62);
      chk("rstmem_005_proto", 32'(o_err + 32'(o_to)), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
